// File: rtl/oled_pixel_streamer.sv
// Raster scanner and MSB-first RGB565 SPI serializer feeding an SSD1331 OLED panel.
// Define OLED_PIXEL_STREAMER_TEST_PATTERN_EN to send x-selected colour bars instead of pixel_data.
module oled_pixel_streamer #(
    parameter int WIDTH     = 96,
    parameter int HEIGHT    = 64,
    parameter int CLK_DIV   = 2,
    parameter int FRAME_GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [12:0] pixel_index,
    output logic        sample_pixel,
    output logic        frame_begin,
    output logic        busy,
    output logic        oled_cs_n,
    output logic        oled_sclk,
    output logic        oled_sdin,
    output logic        oled_dc
);
    // state | meaning
    // IDLE  | waiting for enable, all outputs at rest
    // LOAD  | one cycle: capture colour for current x/y, pulse sample_pixel
    // SHIFT | 16 bits MSB first, CLK_DIV cycles SCLK low then CLK_DIV high per bit
    // GAP   | chip select high for FRAME_GAP cycles between frames
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam logic [6:0]  X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]  Y_LAST   = 6'(HEIGHT - 1);
    localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LOAD = 16'(FRAME_GAP - 1);

    state_t      state;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] capture_data;

`ifdef OLED_PIXEL_STREAMER_TEST_PATTERN_EN
    logic unused_pixel_data;
    assign unused_pixel_data = ^pixel_data;

    always_comb begin
        capture_data = 16'h0000;
        case (x[6:4])
            3'd0:    capture_data = 16'hFFFF;
            3'd1:    capture_data = 16'hF800;
            3'd2:    capture_data = 16'h07E0;
            3'd3:    capture_data = 16'h001F;
            3'd4:    capture_data = 16'hFFE0;
            default: capture_data = 16'h0000;
        endcase
    end
`else
    assign capture_data = pixel_data;
`endif

    // Data bit is the top of the shift register, so it changes with the SCLK fall.
    assign oled_sdin = shreg[15];
    assign oled_dc   = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            pixel_index  <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            sample_pixel <= 1'b0;
            frame_begin  <= 1'b0;
            busy         <= 1'b0;
            oled_cs_n    <= 1'b1;
            oled_sclk    <= 1'b1;
        end else begin
            sample_pixel <= 1'b0;
            frame_begin  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= LOAD;
                        x            <= '0;
                        y            <= '0;
                        pixel_index  <= '0;
                        sample_pixel <= 1'b1;
                        frame_begin  <= 1'b1;
                        busy         <= 1'b1;
                        oled_cs_n    <= 1'b0;
                    end
                end
                LOAD: begin
                    shreg     <= capture_data;
                    bit_cnt   <= '0;
                    div_cnt   <= DIV_LOAD;
                    oled_sclk <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!oled_sclk) begin
                        oled_sclk <= 1'b1;
                        div_cnt   <= DIV_LOAD;
                    end else if (bit_cnt != 4'd15) begin
                        bit_cnt   <= bit_cnt + 4'd1;
                        shreg     <= {shreg[14:0], 1'b0};
                        oled_sclk <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                    end else if (x == X_LAST && y == Y_LAST) begin
                        x           <= '0;
                        y           <= '0;
                        pixel_index <= '0;
                        shreg       <= '0;
                        oled_cs_n   <= 1'b1;
                        gap_cnt     <= GAP_LOAD;
                        state       <= GAP;
                    end else begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 6'd1;
                        end else begin
                            x <= x + 7'd1;
                        end
                        pixel_index  <= pixel_index + 13'd1;
                        sample_pixel <= 1'b1;
                        state        <= LOAD;
                    end
                end
                GAP: begin
                    // Chip select drops entering LOAD, one cycle ahead of the first SCLK fall.
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end else if (enable) begin
                        state        <= LOAD;
                        sample_pixel <= 1'b1;
                        frame_begin  <= 1'b1;
                        oled_cs_n    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer: a 4x2 instance for framing/serialization and a default-size instance for row 0.
module tb_oled_pixel_streamer;
    localparam int W_S = 4;
    localparam int H_S = 2;
    localparam int CD_S = 1;
    localparam int GAP_S = 4;

    logic clk;
    logic rst_n;
    logic en_s, en_b;
    logic raster;
    logic [15:0] pd_s, pd_b;

    logic [6:0]  x_s, x_b;
    logic [5:0]  y_s, y_b;
    logic [12:0] pi_s, pi_b;
    logic sp_s, fb_s, busy_s, cs_s, sclk_s, sdin_s, dc_s;
    logic sp_b, fb_b, busy_b, cs_b, sclk_b, sdin_b, dc_b;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int cs_low = 0;
    logic [15:0] sh_s, sh_b;
    int nb_s, nb_b;
    logic prev_sclk_s = 1'b1;
    logic prev_sclk_b = 1'b1;
    int n, t0, t1, t2, nsamp, nfb;

    logic [15:0] raster_exp [8] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300,
                                    16'h0001, 16'h0101, 16'h0201, 16'h0301};

    oled_pixel_streamer #(.WIDTH(W_S), .HEIGHT(H_S), .CLK_DIV(CD_S), .FRAME_GAP(GAP_S)) u_small (
        .clk(clk), .rst_n(rst_n), .enable(en_s), .pixel_data(pd_s),
        .x(x_s), .y(y_s), .pixel_index(pi_s), .sample_pixel(sp_s), .frame_begin(fb_s),
        .busy(busy_s), .oled_cs_n(cs_s), .oled_sclk(sclk_s), .oled_sdin(sdin_s), .oled_dc(dc_s)
    );

    oled_pixel_streamer u_big (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pixel_data(pd_b),
        .x(x_b), .y(y_b), .pixel_index(pi_b), .sample_pixel(sp_b), .frame_begin(fb_b),
        .busy(busy_b), .oled_cs_n(cs_b), .oled_sclk(sclk_b), .oled_sdin(sdin_b), .oled_dc(dc_b)
    );

    always_comb pd_s = raster ? {1'b0, x_s, 2'b00, y_s} : 16'hA5C3;

`ifdef OLED_PIXEL_STREAMER_TEST_PATTERN_EN
    assign pd_b = 16'h0000;
`else
    assign pd_b = {1'b0, x_b, 8'h3C};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] big_exp(input int p);
`ifdef OLED_PIXEL_STREAMER_TEST_PATTERN_EN
        case (p)
            0:       return 16'hFFFF;
            20:      return 16'hF800;
            40:      return 16'h07E0;
            70:      return 16'hFFE0;
            default: return 16'h0000;
        endcase
`else
        case (p)
            0:       return 16'h003C;
            20:      return 16'h143C;
            40:      return 16'h283C;
            70:      return 16'h463C;
            default: return 16'h5F3C;
        endcase
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step; tracks SCLK rises to rebuild the serialized words.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!prev_sclk_s && sclk_s) begin sh_s = {sh_s[14:0], sdin_s}; nb_s++; end
        if (!prev_sclk_b && sclk_b) begin sh_b = {sh_b[14:0], sdin_b}; nb_b++; end
        prev_sclk_s = sclk_s;
        prev_sclk_b = sclk_b;
        if (!cs_s) cs_low++;
    endtask

    task automatic wait_s(input string tag);
        int k = 0;
        while (!sp_s && k < 20) begin tick(); k++; end
        check(tag, 32'(sp_s), 32'd1);
    endtask

    task automatic recv_s(input string tag, input logic [15:0] exp);
        sh_s = '0;
        nb_s = 0;
        repeat (32 * CD_S) tick();
        check({tag, "_bits"}, nb_s, 16);
        check(tag, 32'(sh_s), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        en_s = 1'b0;
        en_b = 1'b0;
        raster = 1'b0;
        sh_s = '0;
        sh_b = '0;
        nb_s = 0;
        nb_b = 0;

        // Reset held for 5 cycles
        repeat (5) tick();
        check("rst_x", 32'(x_s), 0);
        check("rst_y", 32'(y_s), 0);
        check("rst_pi", 32'(pi_s), 0);
        check("rst_sp", 32'(sp_s), 0);
        check("rst_fb", 32'(fb_s), 0);
        check("rst_busy", 32'(busy_s), 0);
        check("rst_cs", 32'(cs_s), 1);
        check("rst_sclk", 32'(sclk_s), 1);
        check("rst_sdin", 32'(sdin_s), 0);
        check("rst_dc", 32'(dc_s), 1);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_busy", 32'(busy_s), 0);
        check("idle_cs", 32'(cs_s), 1);
        check("idle_sclk", 32'(sclk_s), 1);
        check("idle_sp", 32'(sp_s), 0);

        // Frame 1: constant A5C3
        cs_low = 0;
        en_s = 1'b1;
        wait_s("ser_start");
        check("ser_pi0", 32'(pi_s), 0);
        check("ser_cs_load", 32'(cs_s), 0);
        for (int p = 0; p < 8; p++) begin
            check("ser_fb", 32'(fb_s), 32'(p == 0));
            recv_s("ser_word", 16'hA5C3);
            tick();
            if (p < 7) check("ser_spacing", 32'(sp_s), 1);
            else check("ser_gap_cs", 32'(cs_s), 1);
        end
        check("ser_cs_low", cs_low, 264);
        raster = 1'b1;
        n = 0;
        while (cs_s && n < 20) begin n++; tick(); end
        check("gap_len", n, GAP_S);
        check("gap_restart_sp", 32'(sp_s), 1);
        check("gap_restart_fb", 32'(fb_s), 1);

        // Frame 2: raster order with renderer returning {x,y}
        for (int p = 0; p < 8; p++) begin
            check("ras_pi", 32'(pi_s), p);
            check("ras_x", 32'(x_s), p % W_S);
            check("ras_y", 32'(y_s), p / W_S);
            recv_s("ras_word", raster_exp[p]);
            tick();
            if (p < 7) check("ras_sp", 32'(sp_s), 1);
        end
        n = 0;
        while (cs_s && n < 20) begin n++; tick(); end
        check("ras_gap_len", n, GAP_S);
        check("ras_pi_wrap", 32'(pi_s), 0);
        check("ras_fb_wrap", 32'(fb_s), 1);

        // Frame 3: enable dropped at pixel 2
        for (int p = 0; p < 2; p++) begin
            recv_s("drop_word", raster_exp[p]);
            tick();
        end
        check("drop_pi2", 32'(pi_s), 2);
        en_s = 1'b0;
        t0 = cyc;
        nsamp = 1;
        nfb = 0;
        t1 = 0;
        t2 = 0;
        for (int i = 0; i < 400 && t2 == 0; i++) begin
            tick();
            if (sp_s) nsamp++;
            if (fb_s) nfb++;
            if (cs_s && t1 == 0) t1 = cyc;
            if (!busy_s && t2 == 0) t2 = cyc;
        end
        repeat (40) begin
            tick();
            if (sp_s) nsamp++;
            if (fb_s) nfb++;
        end
        check("drop_samples", nsamp, 6);
        check("drop_no_fb", nfb, 0);
        check("drop_frame_end", t1 - t0, 198);
        check("drop_gap", t2 - t1, GAP_S);
        check("drop_busy", 32'(busy_s), 0);
        check("drop_cs", 32'(cs_s), 1);

        // Reset during data bit 7 of pixel 3
        en_s = 1'b1;
        wait_s("mrst_start");
        check("mrst_fb", 32'(fb_s), 1);
        for (int p = 0; p < 3; p++) begin
            recv_s("mrst_word", raster_exp[p]);
            tick();
        end
        check("mrst_x3", 32'(x_s), 3);
        repeat (17) tick();
        check("mrst_sclk_low", 32'(sclk_s), 0);
        check("mrst_cs_low", 32'(cs_s), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_cs", 32'(cs_s), 1);
        check("mrst_sclk", 32'(sclk_s), 1);
        check("mrst_x", 32'(x_s), 0);
        check("mrst_y", 32'(y_s), 0);
        check("mrst_pi", 32'(pi_s), 0);
        check("mrst_busy", 32'(busy_s), 0);
        check("mrst_sdin", 32'(sdin_s), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_s("mrst_restart");
        check("mrst_restart_fb", 32'(fb_s), 1);
        check("mrst_restart_pi", 32'(pi_s), 0);
        en_s = 1'b0;

        // Default-size instance, first row
        en_b = 1'b1;
        n = 0;
        while (!sp_b && n < 20) begin n++; tick(); end
        check("big_start", 32'(sp_b), 1);
        check("big_fb", 32'(fb_b), 1);
        for (int p = 0; p < 96; p++) begin
            check("big_x", 32'(x_b), p);
            sh_b = '0;
            nb_b = 0;
            repeat (64) tick();
            if (p == 0 || p == 20 || p == 40 || p == 70 || p == 95)
                check("big_word", 32'(sh_b), 32'(big_exp(p)));
            tick();
        end
        check("big_row_sp", 32'(sp_b), 1);
        check("big_row_x", 32'(x_b), 0);
        check("big_row_y", 32'(y_b), 1);
        check("big_row_pi", 32'(pi_b), 96);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/oled_pixel_streamer.md
Name: oled_pixel_streamer

Overview:
- Downstream consumer of the per-pixel colour renderer, which maps (x, y) to a 16-bit RGB565 oled_data.
- Scans the 96x64 OLED raster in raster order and presents x/y to the renderer.
- Samples the returned colour and serializes it MSB-first over the SSD1331 SPI data interface.
- Runs continuously while enabled; frames are separated by a chip-select-high gap.

Parameters:
- WIDTH, 96: pixels per line; x wraps at WIDTH-1.
- HEIGHT, 64: lines per frame; y wraps at HEIGHT-1.
- CLK_DIV, 2: clk cycles per SCLK half-period (>=1).
- FRAME_GAP, 16: clk cycles with oled_cs_n high between frames (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  start or continue streaming frames.
- pixel_data  in  16  RGB565 colour for the current x/y, from the renderer.
- x  out  7  current pixel column.
- y  out  6  current pixel row.
- pixel_index  out  13  y*WIDTH+x.
- sample_pixel  out  1  one-cycle pulse: pixel_data captured this cycle.
- frame_begin  out  1  one-cycle pulse coincident with the sample of pixel 0.
- busy  out  1  high in every state except IDLE.
- oled_cs_n  out  1  SPI chip select, active low.
- oled_sclk  out  1  SPI clock, idles high.
- oled_sdin  out  1  SPI data; the panel samples it on the rising edge of oled_sclk.
- oled_dc  out  1  data/command select; constant 1 (data).

Behaviour:
- Reset (asynchronous, takes effect mid-operation): state=IDLE, x=0, y=0, pixel_index=0, shift register=0, sample_pixel=0, frame_begin=0, busy=0, oled_cs_n=1, oled_sclk=1, oled_sdin=0, oled_dc=1.
- x/y/pixel_index are registered and stay stable for the whole pixel period. The renderer is combinational, so pixel_data is valid in the LOAD cycle.
- States:
  - IDLE: outputs at reset values. If enable=1, go to LOAD next cycle with x=y=0.
  - LOAD (1 cycle): sample_pixel=1; frame_begin=1 iff pixel_index==0. Shift register <= pixel_data at the clock edge. oled_cs_n goes to 0 on the same edge. Next state SHIFT.
  - SHIFT: 16 bits, MSB first. Per bit:
    - oled_sclk=0 for CLK_DIV cycles, with oled_sdin driven to the current bit from the first low cycle.
    - oled_sclk=1 for CLK_DIV cycles.
    - oled_sdin is held through the high phase.
    - Bit counter is 4 bits and is cleared in LOAD.
  - After the high phase of bit 0 (LSB):
    - If not the last pixel: advance x; if x==WIDTH-1, set x=0 and increment y. Then go to LOAD. oled_cs_n stays 0 across pixels in a frame.
    - If last pixel (x==WIDTH-1, y==HEIGHT-1): x=y=0, go to GAP.
  - GAP: oled_cs_n=1, oled_sclk=1, for FRAME_GAP cycles. Then go to LOAD if enable=1, else IDLE.
- Pixel period: exactly 1+32*CLK_DIV cycles. Frame period: WIDTH*HEIGHT*(1+32*CLK_DIV)+FRAME_GAP cycles.
- enable deasserted mid-frame: the current frame completes in full. IDLE is entered only from GAP. No partial frames are ever sent.
- enable asserted during GAP: the next frame starts right after the gap, with no extra IDLE cycle.
- pixel_index is computed incrementally (+1 per pixel, wraps to 0 with the frame); no multiplier.
- busy = (state != IDLE).

Optional Feature:
- Macro: OLED_PIXEL_STREAMER_TEST_PATTERN_EN.
- When defined: pixel_data is ignored; the LOAD cycle captures a colour bar selected by x[6:4]:
  - 0: FFFF
  - 1: F800
  - 2: 07E0
  - 3: 001F
  - 4: FFE0
  - 5 and above: 0000
- Timing and handshakes are unchanged.
- When undefined: pixel_data is captured as specified above.

Test Plan:
- Reset behaviour: WIDTH=4, HEIGHT=2, CLK_DIV=1, FRAME_GAP=4; hold rst_n=0 for 5 cycles, then release with enable=0 -> all outputs at reset values, busy=0 indefinitely.
- Serialization: same params, enable=1, pixel_data=16'hA5C3 constant -> frame_begin one pulse; 8 sample_pixel pulses spaced 33 cycles apart. Bits captured on each oled_sclk rise read A5C3 MSB-first. oled_cs_n is low for 264 cycles, then high for 4.
- Raster order: renderer model returns {x,y} -> captured words 0000,0100,0200,0300,0001,0101,0201,0301 (x in bits 15:8, y in bits 7:0). pixel_index runs 0..7 then wraps to 0.
- Enable drop: deassert enable at pixel 2 -> remaining 6 pixels still sent, 4-cycle gap, then IDLE, busy=0, no further frame_begin.
- Reset mid-shift: assert rst_n=0 during bit 7 of pixel 3 -> oled_cs_n=1, oled_sclk=1, x=y=0 asynchronously. After release with enable=1, frame_begin fires for pixel 0.
- Test pattern: with OLED_PIXEL_STREAMER_TEST_PATTERN_EN defined and the default parameters (96x64, CLK_DIV=2), pixel_data=0 -> pixels at x=0, 20, 40, 70, 95 serialize FFFF, F800, 07E0, FFE0, 0000.
